// File: rtl/sm4_egress_buffer.sv
// Egress buffer for the SM4 pipeline: captures completed blocks into a FWFT FIFO and meters upstream credits.
// Optional SM4_EGRESS_BYTESWAP_EN: present the head block byte-reversed on DAT_o (storage unchanged).
module sm4_egress_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          CLK_i,
    input  logic          RST_i,
    input  logic          ISSUE_i,
    output logic          CREDIT_o,
    input  logic [127:0]  CORE_DAT_i,
    input  logic          CORE_READY_i,
    output logic [127:0]  DAT_o,
    output logic          DAT_VALID_o,
    input  logic          DAT_READY_i,
    output logic [AW:0]   COUNT_o,
    output logic          ERR_o
);

    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] POOL_SIZE = (AW+2)'(DEPTH);

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, infl;
    logic          err;

    logic          full, empty, pop, push, drop, inc, dec, underflow;
    logic [AW+1:0] occupancy;
    logic [127:0]  head, head_out;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A full FIFO still accepts a block when the head leaves in the same cycle.
    assign pop   = !empty && DAT_READY_i;
    assign push  = CORE_READY_i && (!full || pop);
    assign drop  = CORE_READY_i && full && !pop;

    // Credit depends only on registered state so there is no input-to-output path.
    assign occupancy = {1'b0, infl} + {1'b0, count};
    assign CREDIT_o  = (occupancy < POOL_SIZE);

    assign inc       = ISSUE_i && CREDIT_o;
    assign dec       = CORE_READY_i;
    assign underflow = dec && !inc && (infl == '0);

    always_ff @(posedge CLK_i) begin
        if (push)
            mem[wptr] <= CORE_DAT_i;
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            infl  <= '0;
            err   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (inc && !dec)
                infl <= infl + 1'b1;
            else if (dec && !inc && (infl != '0))
                infl <= infl - 1'b1;

            err <= err || drop || underflow;
        end
    end

    assign head = mem[rptr];

`ifdef SM4_EGRESS_BYTESWAP_EN
    for (genvar b = 0; b < 16; b++) begin : g_swap
        assign head_out[8*b +: 8] = head[8*(15-b) +: 8];
    end
`else
    assign head_out = head;
`endif

    assign DAT_VALID_o = !empty;
    assign DAT_o       = empty ? '0 : head_out;
    assign COUNT_o     = count;
    assign ERR_o       = err;

endmodule

// File: tb/tb_sm4_egress_buffer.sv
// Directed bench for sm4_egress_buffer (DEPTH=4): vector table plus hand sequences for reset and byte order.
module tb_sm4_egress_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          CLK_i = 1'b0;
    logic          RST_i = 1'b1;
    logic          ISSUE_i = 1'b0;
    logic          CREDIT_o;
    logic [127:0]  CORE_DAT_i = '0;
    logic          CORE_READY_i = 1'b0;
    logic [127:0]  DAT_o;
    logic          DAT_VALID_o;
    logic          DAT_READY_i = 1'b0;
    logic [AW:0]   COUNT_o;
    logic          ERR_o;

    sm4_egress_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK_i        (CLK_i),
        .RST_i        (RST_i),
        .ISSUE_i      (ISSUE_i),
        .CREDIT_o     (CREDIT_o),
        .CORE_DAT_i   (CORE_DAT_i),
        .CORE_READY_i (CORE_READY_i),
        .DAT_o        (DAT_o),
        .DAT_VALID_o  (DAT_VALID_o),
        .DAT_READY_i  (DAT_READY_i),
        .COUNT_o      (COUNT_o),
        .ERR_o        (ERR_o)
    );

    always #5 CLK_i = ~CLK_i;

    typedef struct {
        logic         issue;
        logic         cr;
        logic [127:0] din;
        logic         rdy;
        logic         credit;
        logic         valid;
        logic [127:0] dout;
        logic [AW:0]  cnt;
        logic         err;
    } vec_t;

    vec_t vq[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = x[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] exp_out(input logic [127:0] x);
`ifdef SM4_EGRESS_BYTESWAP_EN
        return bswap(x);
`else
        return x;
`endif
    endfunction

    function automatic logic [127:0] tag(input int n);
        return {16'hCAFE, 108'h0, 4'(n)};
    endfunction

    function void add(input logic issue, input logic cr, input logic [127:0] din, input logic rdy,
                      input logic credit, input logic valid, input logic [127:0] dout,
                      input logic [AW:0] cnt, input logic err);
        vec_t v;
        v.issue = issue; v.cr = cr; v.din = din; v.rdy = rdy;
        v.credit = credit; v.valid = valid; v.dout = dout; v.cnt = cnt; v.err = err;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic check_all(input string name, input logic credit, input logic valid,
                             input logic [127:0] dout, input logic [AW:0] cnt, input logic err);
        check({name, " credit"}, 128'(CREDIT_o), 128'(credit));
        check({name, " valid"},  128'(DAT_VALID_o), 128'(valid));
        check({name, " dat"},    DAT_o, exp_out(dout));
        check({name, " count"},  128'(COUNT_o), 128'(cnt));
        check({name, " err"},    128'(ERR_o), 128'(err));
    endtask

    initial begin
        logic [127:0] spec_in;
        spec_in = 128'h00112233_44556677_8899AABB_CCDDEEFF;

        // reset state
        repeat (2) @(posedge CLK_i);
        #1;
        check_all("reset", 1'b1, 1'b0, '0, '0, 1'b0);
        RST_i = 1'b0;

        // credit exhaustion: 6 issues, only 4 accepted
        add(1,0,'0,0, 1,0,'0,0,0);
        add(1,0,'0,0, 1,0,'0,0,0);
        add(1,0,'0,0, 1,0,'0,0,0);
        add(1,0,'0,0, 0,0,'0,0,0);
        add(1,0,'0,0, 0,0,'0,0,0);
        add(1,0,'0,0, 0,0,'0,0,0);
        // four returns with downstream stalled, then drain in order
        add(0,1,128'h1,0, 0,1,128'h1,1,0);
        add(0,1,128'h2,0, 0,1,128'h1,2,0);
        add(0,1,128'h3,0, 0,1,128'h1,3,0);
        add(0,1,128'h4,0, 0,1,128'h1,4,0);
        add(0,0,'0,1,     1,1,128'h2,3,0);
        add(0,0,'0,1,     1,1,128'h3,2,0);
        add(0,0,'0,1,     1,1,128'h4,1,0);
        add(0,0,'0,1,     1,0,'0,0,0);
        // refill to full
        add(1,0,'0,0, 1,0,'0,0,0);
        add(1,0,'0,0, 1,0,'0,0,0);
        add(1,0,'0,0, 1,0,'0,0,0);
        add(1,0,'0,0, 0,0,'0,0,0);
        add(0,1,tag(1),0, 0,1,tag(1),1,0);
        add(0,1,tag(2),0, 0,1,tag(1),2,0);
        add(0,1,tag(3),0, 0,1,tag(1),3,0);
        add(0,1,tag(4),0, 0,1,tag(1),4,0);
        // push+pop at full: kept, count stays 4; INFL is 0 so this return is flagged
        add(0,1,tag(5),1, 0,1,tag(2),4,1);
        // push at full without pop: dropped
        add(0,1,tag(6),0, 0,1,tag(2),4,1);
        add(0,0,'0,1, 1,1,tag(3),3,1);
        add(0,0,'0,1, 1,1,tag(4),2,1);
        add(0,0,'0,1, 1,1,tag(5),1,1);
        add(0,0,'0,1, 1,0,'0,0,1);

        foreach (vq[i]) begin
            ISSUE_i      = vq[i].issue;
            CORE_READY_i = vq[i].cr;
            CORE_DAT_i   = vq[i].din;
            DAT_READY_i  = vq[i].rdy;
            @(posedge CLK_i);
            #1;
            check_all($sformatf("v%0d", i), vq[i].credit, vq[i].valid, vq[i].dout, vq[i].cnt, vq[i].err);
        end
        ISSUE_i = 0; CORE_READY_i = 0; DAT_READY_i = 0; CORE_DAT_i = '0;

        // asynchronous reset clears the sticky error
        RST_i = 1'b1;
        #2;
        check_all("rst1", 1'b1, 1'b0, '0, '0, 1'b0);
        @(posedge CLK_i); #1;
        RST_i = 1'b0;

        // stray return with INFL=0 still lands and sets a sticky error
        CORE_READY_i = 1'b1; CORE_DAT_i = tag(9);
        @(posedge CLK_i); #1;
        CORE_READY_i = 1'b0; CORE_DAT_i = '0;
        check_all("stray", 1'b1, 1'b1, tag(9), 3'd1, 1'b1);
        repeat (3) @(posedge CLK_i);
        #1;
        check("sticky err", 128'(ERR_o), 128'(1'b1));
        ISSUE_i = 1'b1;
        @(posedge CLK_i); #1;
        ISSUE_i = 1'b0;
        check_all("busy", 1'b1, 1'b1, tag(9), 3'd1, 1'b1);
        // mid-stream reset, asserted between edges
        #2 RST_i = 1'b1;
        #1;
        check_all("rst2", 1'b1, 1'b0, '0, '0, 1'b0);
        @(posedge CLK_i); #1;
        RST_i = 1'b0;

        // output byte order
        ISSUE_i = 1'b1;
        @(posedge CLK_i); #1;
        ISSUE_i = 1'b0;
        CORE_READY_i = 1'b1; CORE_DAT_i = spec_in;
        DAT_READY_i = 1'b1;
        @(posedge CLK_i); #1;
        CORE_READY_i = 1'b0; CORE_DAT_i = '0;
        check_all("order", 1'b1, 1'b1, spec_in, 3'd1, 1'b0);
`ifdef SM4_EGRESS_BYTESWAP_EN
        check("swap literal", DAT_o, 128'hFFEEDDCC_BBAA9988_77665544_33221100);
`else
        check("plain literal", DAT_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);
`endif
        @(posedge CLK_i); #1;
        DAT_READY_i = 1'b0;
        check_all("drain", 1'b1, 1'b0, '0, '0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
